// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one APB slave among NUM_REQ requesters.
// An idle master picks the first valid requester at or after the round-robin pointer. It latches
// that request into the P* registers and runs SETUP then ACCESS. ACCESS is held until PREADY.
// Read data and error status are returned to the owner. Only one transfer is in flight at a time.
//
// Ports:
//   PCLK, PRESETn        clock (rising edge), asynchronous active-low reset
//   req_valid/req_write  per-requester request and direction (1 = write)
//   req_addr/wdata/strb  flattened per-requester address, write data and byte strobes
//   req_grant            one-hot 1-cycle pulse: request latched
//   rsp_valid            one-hot 1-cycle pulse: transfer finished
//   rsp_rdata, rsp_err   read data / error of the last finished transfer
//   timeout              1-cycle pulse on an aborted transfer
//   PSEL..PSTRB          APB master outputs; PRDATA, PREADY, PSLVERR APB slave inputs
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES
// cycles without PREADY. Without it, ACCESS waits indefinitely and timeout is tied to 0.
module apb_rr_master #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           timeout,
    output logic                           PSEL,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [DATA_WIDTH/8-1:0]        PSTRB,
    input  logic [DATA_WIDTH-1:0]          PRDATA,
    input  logic                           PREADY,
    input  logic                           PSLVERR
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned PTR_W  = $clog2(NUM_REQ);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    rspv_q, rspv_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [PTR_W-1:0]      ptr_next;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    // Round-robin pick: first valid requester at or after ptr_q, wrapping.
    logic             found;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // The owner just served drops to lowest priority.
    assign ptr_next = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        grant_d   = '0;
        rspv_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
        tmo_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d      = win;
                    pwrite_d     = req_write[win];
                    paddr_d      = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_d     = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    pstrb_d      = req_strb[int'(win)*STRB_W +: STRB_W];
                    grant_d[win] = 1'b1;
                    psel_d       = 1'b1;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            StAccess: begin
                if (PREADY) begin
                    psel_d          = 1'b0;
                    penable_d       = 1'b0;
                    rspv_d[owner_q] = 1'b1;
                    err_d           = PSLVERR;
                    if (!pwrite_q) begin
                        rdata_d = PRDATA;
                    end
                    ptr_d   = ptr_next;
                    state_d = StIdle;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    psel_d          = 1'b0;
                    penable_d       = 1'b0;
                    rspv_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                    rdata_d         = '0;
                    tmo_d           = 1'b1;
                    ptr_d           = ptr_next;
                    state_d         = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d   = StIdle;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            owner_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            grant_q   <= '0;
            rspv_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            grant_q   <= grant_d;
            rspv_q    <= rspv_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    assign req_grant = grant_q;
    assign rsp_valid = rspv_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed requests, a wait-stated memory slave and a transfer-level
// reference model compared against every DUT output on every falling clock edge.
module tb_apb_rr_master;

    localparam int NR  = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_write = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR*DW/8-1:0] req_strb = '0;
    logic [NR-1:0]   req_grant, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err, timeout;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW/8-1:0] PSTRB;
    logic [DW-1:0]   PRDATA = 32'hDEAD_BEEF;
    logic            PREADY = 1'b0;
    logic            PSLVERR = 1'b1;

    apb_rr_master #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .timeout(timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #2;
    endtask

    // ---------------- slave: memory with ws wait states, error at addr >= 0xC0 ----------------
    logic [DW-1:0] mem [256];
    int  ws = 0;
    int  wcnt = 0;
    bit  stuck = 0;

    initial for (int i = 0; i < 256; i++) mem[i] = '0;

    always begin
        step();
        if (PSEL && PENABLE) begin
            if (!stuck && wcnt == ws) begin
                PREADY  = 1'b1;
                PSLVERR = (PADDR >= 8'hC0);
                PRDATA  = 32'hDEAD_BEEF;
                if (PWRITE) begin
                    if (!PSLVERR)
                        for (int b = 0; b < 4; b++)
                            if (PSTRB[b]) mem[PADDR][b*8 +: 8] = PWDATA[b*8 +: 8];
                end else begin
                    PRDATA = mem[PADDR];
                end
            end else begin
                PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hDEAD_BEEF;
                wcnt++;
            end
        end else begin
            PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'hDEAD_BEEF;
            wcnt = 0;
        end
    end

    // ---------------- reference model: one transfer at a time, aged in cycles ----------------
    logic [NR-1:0]   e_grant, e_rspv;
    logic            e_psel, e_pen, e_pwrite, e_err, e_tmo;
    logic [AW-1:0]   e_paddr;
    logic [DW-1:0]   e_pwdata, e_rdata;
    logic [DW/8-1:0] e_pstrb;
    bit  busy;
    int  age;      // 0 = setup cycle, k >= 1 = k-th access cycle
    int  owner;
    int  mptr;

    task automatic model_reset();
        e_grant = '0; e_rspv = '0; e_psel = 0; e_pen = 0; e_pwrite = 0; e_err = 0; e_tmo = 0;
        e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_pstrb = '0;
        busy = 0; age = 0; owner = 0; mptr = 0;
    endtask

    task automatic finish_xfer(input logic err, input logic [DW-1:0] rd, input logic tmo);
        e_psel = 0; e_pen = 0;
        e_rspv[owner] = 1'b1;
        e_err = err; e_rdata = rd; e_tmo = tmo;
        mptr = (owner + 1) % NR;
        busy = 0;
    endtask

    // Given what happens in this cycle, set up what the outputs must be next cycle.
    task automatic model_predict();
        int w;
        e_grant = '0; e_rspv = '0; e_tmo = 0;
        if (!busy) begin
            w = -1;
            for (int k = 0; k < NR; k++)
                if (w < 0 && req_valid[(mptr + k) % NR]) w = (mptr + k) % NR;
            if (w >= 0) begin
                owner = w; busy = 1; age = 0;
                e_grant[w] = 1'b1;
                e_psel = 1; e_pen = 0;
                e_pwrite = req_write[w];
                e_paddr  = req_addr[w*AW +: AW];
                e_pwdata = req_wdata[w*DW +: DW];
                e_pstrb  = req_strb[w*4 +: 4];
            end
        end else if (age == 0) begin
            e_pen = 1; age = 1;
        end else if (PREADY) begin
            finish_xfer(PSLVERR, e_pwrite ? e_rdata : PRDATA, 1'b0);
        end
`ifdef APB_TIMEOUT_EN
        else if (age == TMO) begin
            finish_xfer(1'b1, '0, 1'b1);
        end
`endif
        else begin
            age++;
        end
    endtask

    initial model_reset();

    always @(negedge PCLK) begin
        if (!PRESETn) model_reset();
        chk("req_grant", 64'(req_grant), 64'(e_grant));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rspv));
        chk("PSEL",      64'(PSEL),      64'(e_psel));
        chk("PENABLE",   64'(PENABLE),   64'(e_pen));
        chk("PWRITE",    64'(PWRITE),    64'(e_pwrite));
        chk("PADDR",     64'(PADDR),     64'(e_paddr));
        chk("PWDATA",    64'(PWDATA),    64'(e_pwdata));
        chk("PSTRB",     64'(PSTRB),     64'(e_pstrb));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
        chk("rsp_err",   64'(rsp_err),   64'(e_err));
        chk("timeout",   64'(timeout),   64'(e_tmo));
        if (PRESETn) model_predict();
    end

    // ---------------- directed transfer helper ----------------
    task automatic issue(input int r, input bit w, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [3:0] rv, output logic [31:0] rd,
                         output logic er, output logic to, output int lat, output int pen);
        bit got;
        step();
        req_write[r] = w;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
        req_strb[r*4 +: 4] = s;
        req_valid[r] = 1'b1;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge PCLK);
            if (req_grant[r]) got = 1;
        end
        chk("grant_seen", 64'(got), 64'd1);
        step();
        req_valid[r] = 1'b0;
        rv = '0; rd = '0; er = 0; to = 0; lat = 0; pen = 0;
        for (int i = 0; i < 100 && rv == 0; i++) begin
            @(negedge PCLK);
            lat++;
            if (PENABLE) pen++;
            if (rsp_valid != 0) begin
                rv = rsp_valid; rd = rsp_rdata; er = rsp_err; to = timeout;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_bad);
        $fatal(1);
    end

    initial begin
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        er, to;
        int          lat, pen;
        logic [3:0]  g [5];
        logic [3:0]  exp_g [5];
        int          ng;
        bit          low_seen, gap_ok, got;

        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // 1: write 0xA5A5A5A5 to 0x10 from requester 0 with 4 wait states
        repeat (2) step();
        PRESETn = 1'b1;
        ws = 4;
        issue(0, 1'b1, 8'h10, 32'hA5A5_A5A5, 4'hF, rv, rd, er, to, lat, pen);
        chk("t1_rsp_valid", 64'(rv), 64'h1);
        chk("t1_rsp_err", 64'(er), 64'h0);
        chk("t1_latency", 64'(lat), 64'd6);
        chk("t1_penable_cycles", 64'(pen), 64'd5);

        // 2: read back from requester 2, 1 wait state
        ws = 1;
        issue(2, 1'b0, 8'h10, 32'h0, 4'h0, rv, rd, er, to, lat, pen);
        chk("t2_rsp_valid", 64'(rv), 64'h4);
        chk("t2_rsp_rdata", 64'(rd), 64'hA5A5_A5A5);
        chk("t2_rsp_err", 64'(er), 64'h0);
        chk("t2_latency", 64'(lat), 64'd3);

        // 3: all four requesting continuously after a reset -> rotating grants
        step(); PRESETn = 1'b0;
        step(); step(); PRESETn = 1'b1;
        ws = 0;
        for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 8'(8'h20 + i);
        req_write = '0;
        req_valid = 4'b1111;
        ng = 0; low_seen = 0; gap_ok = 1;
        for (int i = 0; i < 100 && ng < 5; i++) begin
            @(negedge PCLK);
            if (req_grant != 0) begin
                if (ng > 0) gap_ok &= low_seen;
                low_seen = 0;
                g[ng] = req_grant;
                ng++;
            end else if (!PSEL) begin
                low_seen = 1;
            end
        end
        step();
        req_valid = '0;
        chk("t3_grant_count", 64'(ng), 64'd5);
        for (int i = 0; i < 5; i++) chk("t3_grant_order", 64'(g[i]), 64'(exp_g[i]));
        chk("t3_idle_gap", 64'(gap_ok), 64'd1);
        repeat (8) step();

        // 4: write into the error region, then a normal read still proceeds
        issue(1, 1'b1, 8'hC0, 32'h1234_5678, 4'hF, rv, rd, er, to, lat, pen);
        chk("t4_rsp_valid", 64'(rv), 64'h2);
        chk("t4_rsp_err", 64'(er), 64'h1);
        issue(2, 1'b0, 8'h10, 32'h0, 4'h0, rv, rd, er, to, lat, pen);
        chk("t4b_rsp_valid", 64'(rv), 64'h4);
        chk("t4b_rsp_err", 64'(er), 64'h0);
        chk("t4b_rsp_rdata", 64'(rd), 64'hA5A5_A5A5);

        // 5: reset during ACCESS; a request that drops before grant is ignored
        ws = 10;
        step();
        req_write[1] = 1'b1;
        req_addr[1*AW +: AW] = 8'h44;
        req_wdata[1*DW +: DW] = 32'h0BAD_F00D;
        req_strb[1*4 +: 4] = 4'h3;
        req_valid[1] = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge PCLK);
            if (req_grant[1]) got = 1;
        end
        chk("t5_grant_seen", 64'(got), 64'd1);
        step(); req_valid[1] = 1'b0; req_valid[2] = 1'b1;
        step(); req_valid[2] = 1'b0;
        chk("t5_in_access", 64'({PSEL, PENABLE}), 64'h3);
        step(); PRESETn = 1'b0;
        #1;
        chk("t5_reset_psel", 64'(PSEL), 64'h0);
        chk("t5_reset_penable", 64'(PENABLE), 64'h0);
        chk("t5_reset_paddr", 64'(PADDR), 64'h0);
        chk("t5_reset_pwdata", 64'(PWDATA), 64'h0);
        chk("t5_reset_rdata", 64'(rsp_rdata), 64'h0);
        req_valid = 4'b1111;
        req_write = '0;
        ws = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge PCLK);
            chk("t5_no_rsp_in_reset", 64'(rsp_valid), 64'h0);
        end
        step(); PRESETn = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge PCLK);
            if (req_grant != 0) begin
                got = 1;
                chk("t5_first_grant", 64'(req_grant), 64'h1);
            end
        end
        chk("t5_grant_after_reset", 64'(got), 64'd1);
        step(); req_valid = '0;
        repeat (10) step();

`ifdef APB_TIMEOUT_EN
        // 6: slave never ready -> abort after TMO access cycles
        stuck = 1;
        issue(0, 1'b0, 8'h30, 32'h0, 4'h0, rv, rd, er, to, lat, pen);
        chk("t6_rsp_valid", 64'(rv), 64'h1);
        chk("t6_rsp_err", 64'(er), 64'h1);
        chk("t6_rsp_rdata", 64'(rd), 64'h0);
        chk("t6_timeout", 64'(to), 64'h1);
        chk("t6_latency", 64'(lat), 64'd17);
        chk("t6_penable_cycles", 64'(pen), 64'd16);
        stuck = 0;
        repeat (4) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
